// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw inputs and repeat enables in,
// conditioned pulses and debounced levels out.
interface button_conditioner_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] bIn;
    logic [N_CH-1:0] repeat_en;
    logic [N_CH-1:0] bOut;
    logic [N_CH-1:0] held;
    logic            any_pulse;

    modport master (
        output bIn,
        output repeat_en,
        input  bOut,
        input  held,
        input  any_pulse
    );

    modport slave (
        input  bIn,
        input  repeat_en,
        output bOut,
        output held,
        output any_pulse
    );
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: 2-flop synchroniser, debounce, and a
// per-channel IDLE/PULSE/HOLD machine producing press and auto-repeat pulses.
module button_conditioner #(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_WIDTH     = 1,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_PERIOD   = 8,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    button_conditioner_if.slave btn_if
);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PW_W  = $clog2(PULSE_WIDTH + 1);
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [N_CH-1:0] IDLE_LVL = {N_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] held_vec;
    logic [N_CH-1:0] bout_vec;
    logic [N_CH-1:0] bout_next;
    logic            any_pulse_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= IDLE_LVL;
            sync2_q     <= IDLE_LVL;
            any_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= btn_if.bIn;
            sync2_q     <= sync1_q;
            any_pulse_q <= |bout_next;
        end
    end

    // XOR with the idle level turns either polarity into pressed = 1
    assign pressed = sync2_q ^ IDLE_LVL;

    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        logic [DB_W-1:0]  db_cnt_q;
        logic [DB_W-1:0]  db_cnt_d;
        logic             held_q;
        logic             held_d;
        state_e           state_q;
        state_e           state_d;
        logic [PW_W-1:0]  pw_cnt_q;
        logic [PW_W-1:0]  pw_cnt_d;
        logic [RPT_W-1:0] rpt_q;
        logic [RPT_W-1:0] rpt_d;
        logic             first_q;
        logic             first_d;
        logic             bout_q;
        logic             bout_d;
        logic [RPT_W-1:0] rpt_limit;
        logic             rpt_expired;

        // Debounce: count consecutive disagreeing samples, toggle on the last one
        always_comb begin
            db_cnt_d = '0;
            held_d   = held_q;
            if (pressed[ch] != held_q) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    held_d = ~held_q;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        assign rpt_limit   = first_q ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_PERIOD);
        assign rpt_expired = (rpt_q >= rpt_limit);

        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt_q <= '0;
                held_q   <= 1'b0;
                state_q  <= IDLE;
                pw_cnt_q <= '0;
                rpt_q    <= '0;
                first_q  <= 1'b0;
                bout_q   <= 1'b0;
            end else begin
                db_cnt_q <= db_cnt_d;
                held_q   <= held_d;
                state_q  <= state_d;
                pw_cnt_q <= pw_cnt_d;
                rpt_q    <= rpt_d;
                first_q  <= first_d;
                bout_q   <= bout_d;
            end
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                IDLE:    if (held_q) state_d = PULSE;
                PULSE:   if (pw_cnt_q == PW_W'(PULSE_WIDTH)) state_d = HOLD;
                HOLD: begin
                    if (!held_q) begin
                        state_d = IDLE;
                    end else if (btn_if.repeat_en[ch] && rpt_expired) begin
                        state_d = PULSE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Timers restart on every PULSE entry; the repeat timer saturates once expired
        always_comb begin
            pw_cnt_d = pw_cnt_q;
            rpt_d    = rpt_q;
            first_d  = first_q;
            bout_d   = (state_d == PULSE);
            if (state_d == PULSE && state_q != PULSE) begin
                pw_cnt_d = PW_W'(1);
                rpt_d    = RPT_W'(1);
                first_d  = (state_q == IDLE);
            end else begin
                pw_cnt_d = (state_d == PULSE) ? pw_cnt_q + PW_W'(1) : '0;
                if (state_d == IDLE) begin
                    rpt_d = '0;
                end else if (!rpt_expired) begin
                    rpt_d = rpt_q + RPT_W'(1);
                end
            end
        end

        assign held_vec[ch]  = held_q;
        assign bout_vec[ch]  = bout_q;
        assign bout_next[ch] = bout_d;
    end

    assign btn_if.bOut      = bout_vec;
    assign btn_if.held      = held_vec;
    assign btn_if.any_pulse = any_pulse_q;
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus,
// checked every cycle against a timestamp-based behavioural model.
module tb_button_conditioner;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   model_valid = 1'b0;

    button_conditioner_if #(.N_CH(4)) ifa ();
    button_conditioner_if #(.N_CH(4)) ifb ();

    button_conditioner #(
        .N_CH(4), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(1),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .btn_if(ifa)
    );

    button_conditioner #(
        .N_CH(4), .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(3),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .btn_if(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel model state: sampled raw history, debounce run length,
    // and the edge number of the most recent pulse start.
    typedef struct packed {
        bit s1;
        bit s2;
        bit held;
        bit active;
        bit bout;
        int run;
        int s;
        int intv;
    } ch_m_t;

    ch_m_t ma [4];
    ch_m_t mb [4];

    function automatic ch_m_t step(input ch_m_t m, input bit raw, input bit ren,
                                   input bit rst_s, input bit al, input int pw,
                                   input int now);
        ch_m_t n;
        bit pressed_old;
        bit held_before;
        n = m;
        if (rst_s) begin
            n.s1 = al; n.s2 = al; n.held = 1'b0; n.active = 1'b0; n.bout = 1'b0;
            n.run = 0; n.s = -1000000; n.intv = 0;
            return n;
        end
        pressed_old = m.s2 ^ al;
        held_before = m.held;
        n.s1 = raw;
        n.s2 = m.s1;
        if (pressed_old != held_before) begin
            n.run = m.run + 1;
            if (n.run == DB) begin
                n.held = ~held_before;
                n.run  = 0;
            end
        end else begin
            n.run = 0;
        end
        n.bout = 1'b0;
        if (now - m.s < pw) begin
            n.bout = 1'b1;
        end else if (now - m.s == pw) begin
            n.bout = 1'b0;
        end else if (!m.active) begin
            if (held_before) begin
                n.s = now; n.intv = RD; n.active = 1'b1; n.bout = 1'b1;
            end
        end else if (!held_before) begin
            n.active = 1'b0;
        end else if (ren && (now - m.s >= m.intv)) begin
            n.s = now; n.intv = RP; n.bout = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int c = 0; c < 4; c++) begin
            ma[c] = step(ma[c], ifa.bIn[c], ifa.repeat_en[c], rst, 1'b1, 1, cyc);
            mb[c] = step(mb[c], ifb.bIn[c], ifb.repeat_en[c], rst, 1'b0, 3, cyc);
        end
        if (rst) model_valid = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [3:0] eb_a, eh_a, eb_b, eh_b;
        if (model_valid) begin
            for (int c = 0; c < 4; c++) begin
                eb_a[c] = ma[c].bout; eh_a[c] = ma[c].held;
                eb_b[c] = mb[c].bout; eh_b[c] = mb[c].held;
            end
            check("model_a_bOut", ifa.bOut, eb_a);
            check("model_a_held", ifa.held, eh_a);
            check("model_a_any", ifa.any_pulse, |eb_a);
            check("model_b_bOut", ifb.bOut, eb_b);
            check("model_b_held", ifb.held, eh_b);
            check("model_b_any", ifb.any_pulse, |eb_b);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_bOut"}, ifa.bOut, 0);
        check({tag, "_a_held"}, ifa.held, 0);
        check({tag, "_a_any"}, ifa.any_pulse, 0);
        check({tag, "_b_bOut"}, ifb.bOut, 0);
        check({tag, "_b_held"}, ifb.held, 0);
        check({tag, "_b_any"}, ifb.any_pulse, 0);
    endtask

    initial begin
        int dwell_a [4];
        int dwell_b [4];
        rst = 1'b1;
        ifa.bIn = 4'hF; ifa.repeat_en = 4'h0;
        ifb.bIn = 4'h0; ifb.repeat_en = 4'h0;
        idle(2);
        check_all_zero("reset");
        rst = 1'b0;
        idle(5);

        // Clean press on A ch0, active-high 3-clock pulse on B ch0
        ifa.bIn[0] = 1'b0;
        ifb.bIn[0] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check("press_a_bOut0", ifa.bOut[0], 32'(i == 7));
            check("press_a_held0", ifa.held[0], 32'(i >= 6));
            check("polarity_b_bOut0", ifb.bOut[0], 32'(i >= 7 && i <= 9));
        end
        ifa.bIn[0] = 1'b1;
        ifb.bIn[0] = 1'b0;
        idle(20);

        // Bounce on ch1: two samples each way never reaches the debounce count
        for (int i = 0; i < 20; i++) begin
            ifa.bIn[1] = ((i % 4) < 2) ? 1'b0 : 1'b1;
            @(negedge clk);
            check("bounce_bOut1", ifa.bOut[1], 0);
            check("bounce_held1", ifa.held[1], 0);
        end
        ifa.bIn[1] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bounce_tail_held1", ifa.held[1], 0);
        end
        idle(10);

        // Auto-repeat on ch2
        ifa.bIn[2] = 1'b0;
        ifa.repeat_en[2] = 1'b1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            check("repeat_bOut2", ifa.bOut[2],
                  32'(i == 7 || i == 27 || i == 35 || i == 43 || i == 51 || i == 59));
            if (i == 60) ifa.bIn[2] = 1'b1;
        end
        ifa.repeat_en[2] = 1'b0;
        idle(10);

        // Simultaneous press on all channels
        ifa.bIn = 4'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("simul_bOut", ifa.bOut, (i == 7) ? 32'hF : 32'h0);
            check("simul_any", ifa.any_pulse, 32'(i == 7));
        end
        ifa.bIn = 4'hF;
        idle(20);

        // Reset while ch2 sits in HOLD, button still down across it
        ifa.bIn[2] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("prereset_bOut2", ifa.bOut[2], 32'(i == 7));
        end
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            check("postreset_bOut2", ifa.bOut[2], 32'(j == 7));
            check("postreset_held2", ifa.held[2], 32'(j >= 6));
        end
        ifa.bIn[2] = 1'b1;
        idle(20);

        // Random phase: mix of short bounces and long holds, toggled repeat enables
        for (int c = 0; c < 4; c++) begin
            dwell_a[c] = $urandom_range(4, 70);
            dwell_b[c] = $urandom_range(4, 70);
        end
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            for (int c = 0; c < 4; c++) begin
                if (dwell_a[c] == 0) begin
                    ifa.bIn[c] = ~ifa.bIn[c];
                    dwell_a[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                             : $urandom_range(4, 70);
                end else begin
                    dwell_a[c] = dwell_a[c] - 1;
                end
                if (dwell_b[c] == 0) begin
                    ifb.bIn[c] = ~ifb.bIn[c];
                    dwell_b[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                             : $urandom_range(4, 70);
                end else begin
                    dwell_b[c] = dwell_b[c] - 1;
                end
                if ($urandom_range(0, 39) == 0) ifa.repeat_en[c] = ~ifa.repeat_en[c];
                if ($urandom_range(0, 39) == 0) ifb.repeat_en[c] = ~ifb.repeat_en[c];
            end
        end
        rst = 1'b0;
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
